sdp_y_inp_chn_out_skid: RTL
===========================

SDP_Y_INP_CHN_OUT_SKID -- requirements
Module: sdp_y_inp_chn_out_skid

Interface
REQ-001 Parameter WIDTH, default 512: width of one output transfer, in bits.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 nvdla_core_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 nvdla_core_rstn  input  1  asynchronous active-low reset.
REQ-006 chn_inp_out_rsci_d  input  WIDTH  data beat from the core.
REQ-007 chn_inp_out_rsci_vld  input  1  core offers a beat this cycle.
REQ-008 chn_inp_out_rsci_rdy  output  1  block accepts a beat this cycle.
REQ-009 chn_inp_out_rsc_z  output  WIDTH  data to the downstream consumer.
REQ-010 chn_inp_out_rsc_lz  output  1  downstream valid.
REQ-011 chn_inp_out_rsc_vz  input  1  downstream ready.
REQ-012 chn_inp_out_rsci_bawt  output  1  buffer holds at least one beat.
REQ-013 chn_inp_out_stall_cnt  output  CNT_W  count of cycles with lz=1 and vz=0.

Function
REQ-014 A push SHALL occur when vld=1 and rdy=1; a pop SHALL occur when lz=1 and vz=1.
REQ-015 Storage SHALL be a 2-entry skid buffer (head and skid registers) with occupancy in the range 0..2.
REQ-016 rdy SHALL be driven only from registers: rdy=1 exactly when occupancy<2; it SHALL NOT depend combinationally on vz.
REQ-017 lz SHALL equal (occupancy>0), and z SHALL equal the head register; both SHALL be register outputs.
REQ-018 Latency: a beat pushed in cycle N SHALL appear on z with lz=1 in cycle N+1 when occupancy was 0.
REQ-019 Occupancy 0, push: the beat SHALL go to head, and occupancy SHALL become 1.
REQ-020 Occupancy 1, push and pop in the same cycle: the new beat SHALL go to head, and occupancy SHALL stay 1.
REQ-021 Occupancy 1, push without pop: the beat SHALL go to skid, and occupancy SHALL become 2.
REQ-022 Occupancy 1, pop without push: occupancy SHALL become 0.
REQ-023 Occupancy 2, pop: skid SHALL move to head, and occupancy SHALL become 1; no push is possible because rdy=0.
REQ-024 Order SHALL be strictly FIFO; no beat SHALL be dropped or duplicated.
REQ-025 While lz=1 and vz=0, z SHALL hold stable and lz SHALL stay 1.
REQ-026 Sustained vld=1 and vz=1 SHALL give one beat per cycle with no bubbles.
REQ-027 bawt SHALL equal lz.
REQ-028 stall_cnt SHALL increment by 1 in each cycle with lz=1 and vz=0, and SHALL saturate at 2^CNT_W-1.
REQ-029 vld with rdy=0 SHALL be ignored; the core holds its data.
REQ-030 Data registers SHALL load only on push or shift, so that unused bits do not toggle.

Reset
REQ-031 On rstn=0, the following SHALL be reset immediately and asynchronously: occupancy=0, lz=0, bawt=0, rdy=1 after release, stall_cnt=0.
REQ-032 Data registers SHALL NOT require reset; z SHALL be don't-care while lz=0.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered beats.
REQ-034 The first push SHALL be accepted in the first clock after rstn rises.

Structure
REQ-035 The shared package sdp_y_inp_pkg SHALL hold the default WIDTH (512), the default CNT_W (16), and the occupancy encoding constants OCC_EMPTY=0, OCC_ONE=1 and OCC_FULL=2.
REQ-036 A single sub-module, sdp_y_inp_skid_reg2, SHALL implement the 2-entry storage and occupancy; the top level SHALL add the stall counter and port mapping.

Verification
REQ-037 Reset, then push 0xA5 with vz=1 -> next cycle lz=1, z=0xA5; one cycle later lz=0, stall_cnt=0.
REQ-038 vz=0, push 0x1 then 0x2 -> after the 2nd push, rdy=0; a third vld is ignored; z=0x1 is held; stall_cnt increments each cycle.
REQ-039 From full, vz=1 for 2 cycles -> outputs 0x1 then 0x2; rdy=1 after the first pop; lz=0 after the second.
REQ-040 vld=1 and vz=1 continuously for 100 beats with incrementing data -> 100 consecutive beats out, in order, with no gaps.
REQ-041 Random vld and vz over 10k cycles -> scoreboard shows no loss or reorder; z stable while lz=1 and vz=0.
REQ-042 Assert rstn=0 with occupancy 2 -> lz=0 and stall_cnt=0 immediately, before the next clock edge; after release rdy=1 and buffered data is gone.

Source files
------------

// File: rtl/sdp_y_inp_pkg.sv
// Shared constants for the SDP Y-input channel output skid stage.
package sdp_y_inp_pkg;
  localparam int DEF_WIDTH = 512;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;
endpackage

// File: rtl/sdp_y_inp_skid_reg2.sv
// Two-entry skid buffer: head feeds the output, skid catches the beat accepted while the head stalls.
module sdp_y_inp_skid_reg2
  import sdp_y_inp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             push_rdy_o,
  input  logic             pop_rdy_i,
  output logic             pop_vld_o,
  output logic [WIDTH-1:0] pop_data_o
);

  occ_e             occ_q, occ_d;
  logic             rdy_q, lz_q;
  logic [WIDTH-1:0] head_q, head_d, skid_q;
  logic             head_en, skid_en;
  logic             push, pop;

  assign push = push_vld_i & rdy_q;
  assign pop  = lz_q & pop_rdy_i;

  always_comb begin
    occ_d   = occ_q;
    head_d  = push_data_i;
    head_en = 1'b0;
    skid_en = 1'b0;
    case (occ_q)
      OCC_EMPTY: if (push) begin
        head_en = 1'b1;
        occ_d   = OCC_ONE;
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_en = 1'b1;
        end else if (push) begin
          skid_en = 1'b1;
          occ_d   = OCC_FULL;
        end else if (pop) begin
          occ_d   = OCC_EMPTY;
        end
      end
      OCC_FULL: if (pop) begin
        head_d  = skid_q;
        head_en = 1'b1;
        occ_d   = OCC_ONE;
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // rdy/lz are registered copies of the next occupancy so neither depends on downstream ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= OCC_EMPTY;
      rdy_q <= 1'b1;
      lz_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      rdy_q <= (occ_d != OCC_FULL);
      lz_q  <= (occ_d != OCC_EMPTY);
    end
  end

  always_ff @(posedge clk_i) begin
    if (head_en) head_q <= head_d;
    if (skid_en) skid_q <= push_data_i;
  end

  assign push_rdy_o = rdy_q;
  assign pop_vld_o  = lz_q;
  assign pop_data_o = head_q;

endmodule

// File: rtl/sdp_y_inp_chn_out_skid.sv
// Channel output stage: skid buffer plus a saturating count of downstream back-pressure cycles.
module sdp_y_inp_chn_out_skid
  import sdp_y_inp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic [WIDTH-1:0] chn_inp_out_rsci_d,
  input  logic             chn_inp_out_rsci_vld,
  output logic             chn_inp_out_rsci_rdy,
  output logic [WIDTH-1:0] chn_inp_out_rsc_z,
  output logic             chn_inp_out_rsc_lz,
  input  logic             chn_inp_out_rsc_vz,
  output logic             chn_inp_out_rsci_bawt,
  output logic [CNT_W-1:0] chn_inp_out_stall_cnt
);

  logic             lz;
  logic [CNT_W-1:0] stall_cnt_q;

  sdp_y_inp_skid_reg2 #(.WIDTH(WIDTH)) u_skid (
    .clk_i       (nvdla_core_clk),
    .rst_ni      (nvdla_core_rstn),
    .push_vld_i  (chn_inp_out_rsci_vld),
    .push_data_i (chn_inp_out_rsci_d),
    .push_rdy_o  (chn_inp_out_rsci_rdy),
    .pop_rdy_i   (chn_inp_out_rsc_vz),
    .pop_vld_o   (lz),
    .pop_data_o  (chn_inp_out_rsc_z)
  );

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)
      stall_cnt_q <= '0;
    else if (lz && !chn_inp_out_rsc_vz && stall_cnt_q != '1)
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign chn_inp_out_rsc_lz    = lz;
  assign chn_inp_out_rsci_bawt = lz;
  assign chn_inp_out_stall_cnt = stall_cnt_q;

endmodule
